// File: rtl/pong_game_sequencer_if.sv
// -----------------------------------------------------------------------------
// pong_game_sequencer_if
// Groups the match controller's front-panel, ball and paddle-control signals.
// The clock and reset stay as plain ports on the controller.
//   i_Ready_Btn, i_Serve_Btn : debounced button levels into the controller
//   i_Miss_P1, i_Miss_P2     : ball miss flags into the controller
//   o_Paddle_Reset           : level, high while the match is on the home screen
//   o_Ready, o_Start, o_Out  : single-cycle paddle/ball control pulses
//   o_Score_P1, o_Score_P2   : player scores (SW bits each)
//   o_Game_Over, o_Winner    : match result (o_Winner 0 = P1, 1 = P2)
//   o_State                  : state encoding for the overlay
// Modports: slave = the controller, master = whoever drives the inputs.
// -----------------------------------------------------------------------------
interface pong_game_sequencer_if #(
    parameter int SW = 4
);
    logic          i_Ready_Btn;
    logic          i_Serve_Btn;
    logic          i_Miss_P1;
    logic          i_Miss_P2;
    logic          o_Paddle_Reset;
    logic          o_Ready;
    logic          o_Start;
    logic          o_Out;
    logic [SW-1:0] o_Score_P1;
    logic [SW-1:0] o_Score_P2;
    logic          o_Game_Over;
    logic          o_Winner;
    logic [2:0]    o_State;

    modport slave (
        input  i_Ready_Btn, i_Serve_Btn, i_Miss_P1, i_Miss_P2,
        output o_Paddle_Reset, o_Ready, o_Start, o_Out,
        output o_Score_P1, o_Score_P2, o_Game_Over, o_Winner, o_State
    );

    modport master (
        output i_Ready_Btn, i_Serve_Btn, i_Miss_P1, i_Miss_P2,
        input  o_Paddle_Reset, o_Ready, o_Start, o_Out,
        input  o_Score_P1, o_Score_P2, o_Game_Over, o_Winner, o_State
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// -----------------------------------------------------------------------------
// pong_game_sequencer
// Top-level Pong match controller: home screen -> serve -> rally -> point pause
// -> ... -> game over. Keeps both scores and drives the paddles' controls.
// Ports:
//   i_Clk   : system/pixel clock
//   i_Reset : synchronous active-high reset
//   bus     : pong_game_sequencer_if.slave (buttons, miss flags, paddle
//             controls, scores, game-over/winner, state code)
// Every output is a register updated in the same cycle as the state register.
// -----------------------------------------------------------------------------
module pong_game_sequencer #(
    parameter int SCORE_MAX   = 9,
    parameter int POINT_DELAY = 25000000,
    parameter int AUTO_SERVE  = 50000000,
    localparam int SW         = $clog2(SCORE_MAX + 1)
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    pong_game_sequencer_if.slave    bus
);
    localparam int CNT_TOP = (POINT_DELAY > AUTO_SERVE) ? POINT_DELAY : AUTO_SERVE;
    localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

    localparam logic [CW-1:0] SERVE_LAST = CW'(AUTO_SERVE - 1);
    localparam logic [CW-1:0] POINT_LAST = CW'(POINT_DELAY - 1);
    localparam logic [SW-1:0] SCORE_TOP  = SW'(SCORE_MAX);

    typedef enum logic [2:0] {
        ST_HOME      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t        r_state,  w_state_next;
    logic [CW-1:0] r_cnt,    w_cnt_next;
    logic [SW-1:0] r_p1,     w_p1_next;
    logic [SW-1:0] r_p2,     w_p2_next;
    logic          r_paddle_reset, w_paddle_reset_next;
    logic          r_ready,  w_ready_next;
    logic          r_start,  w_start_next;
    logic          r_out,    w_out_next;
    logic          r_game_over, w_game_over_next;
    logic          r_winner, w_winner_next;
    logic          r_prev_ready, r_prev_serve;

    logic w_ready_rise, w_serve_rise;

    // Previous-level registers come out of reset high so a button already
    // held down when reset releases does not look like a fresh press.
    assign w_ready_rise = bus.i_Ready_Btn & ~r_prev_ready;
    assign w_serve_rise = bus.i_Serve_Btn & ~r_prev_serve;

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_p1_next           = r_p1;
        w_p2_next           = r_p2;
        w_winner_next       = r_winner;
        w_paddle_reset_next = 1'b0;
        w_game_over_next    = 1'b0;
        w_ready_next        = 1'b0;
        w_start_next        = 1'b0;
        w_out_next          = 1'b0;

        case (r_state)
            ST_HOME: begin
                w_paddle_reset_next = 1'b1;
                w_p1_next           = '0;
                w_p2_next           = '0;
                if (w_ready_rise) begin
                    w_state_next        = ST_SERVE;
                    w_paddle_reset_next = 1'b0;
                    w_ready_next        = 1'b1;
                    w_cnt_next          = '0;
                end
            end
            ST_SERVE: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_serve_rise || (r_cnt == SERVE_LAST)) begin
                    w_state_next = ST_PLAY;
                    w_start_next = 1'b1;
                    w_cnt_next   = '0;
                end
            end
            ST_PLAY: begin
                if (bus.i_Miss_P1 || bus.i_Miss_P2) begin
                    // A simultaneous double miss ends the rally without a point.
                    if (bus.i_Miss_P1 && !bus.i_Miss_P2 && (r_p2 != SCORE_TOP))
                        w_p2_next = r_p2 + 1'b1;
                    if (bus.i_Miss_P2 && !bus.i_Miss_P1 && (r_p1 != SCORE_TOP))
                        w_p1_next = r_p1 + 1'b1;
                    w_out_next = 1'b1;
                    w_cnt_next = '0;
                    if (w_p1_next == SCORE_TOP) begin
                        w_state_next     = ST_GAME_OVER;
                        w_game_over_next = 1'b1;
                        w_winner_next    = 1'b0;
                    end else if (w_p2_next == SCORE_TOP) begin
                        w_state_next     = ST_GAME_OVER;
                        w_game_over_next = 1'b1;
                        w_winner_next    = 1'b1;
                    end else begin
                        w_state_next = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == POINT_LAST) begin
                    w_state_next = ST_SERVE;
                    w_cnt_next   = '0;
                end
            end
            ST_GAME_OVER: begin
                w_game_over_next = 1'b1;
                if (w_ready_rise) begin
                    w_state_next        = ST_HOME;
                    w_game_over_next    = 1'b0;
                    w_paddle_reset_next = 1'b1;
                    w_p1_next           = '0;
                    w_p2_next           = '0;
                    w_winner_next       = 1'b0;
                    w_cnt_next          = '0;
                end
            end
            default: begin
                // Unused encodings recover to the home screen.
                w_state_next        = ST_HOME;
                w_paddle_reset_next = 1'b1;
                w_p1_next           = '0;
                w_p2_next           = '0;
                w_winner_next       = 1'b0;
                w_cnt_next          = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state        <= ST_HOME;
            r_cnt          <= '0;
            r_p1           <= '0;
            r_p2           <= '0;
            r_paddle_reset <= 1'b1;
            r_ready        <= 1'b0;
            r_start        <= 1'b0;
            r_out          <= 1'b0;
            r_game_over    <= 1'b0;
            r_winner       <= 1'b0;
            r_prev_ready   <= 1'b1;
            r_prev_serve   <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_p1           <= w_p1_next;
            r_p2           <= w_p2_next;
            r_paddle_reset <= w_paddle_reset_next;
            r_ready        <= w_ready_next;
            r_start        <= w_start_next;
            r_out          <= w_out_next;
            r_game_over    <= w_game_over_next;
            r_winner       <= w_winner_next;
            r_prev_ready   <= bus.i_Ready_Btn;
            r_prev_serve   <= bus.i_Serve_Btn;
        end
    end

    assign bus.o_Paddle_Reset = r_paddle_reset;
    assign bus.o_Ready        = r_ready;
    assign bus.o_Start        = r_start;
    assign bus.o_Out          = r_out;
    assign bus.o_Score_P1     = r_p1;
    assign bus.o_Score_P2     = r_p2;
    assign bus.o_Game_Over    = r_game_over;
    assign bus.o_Winner       = r_winner;
    assign bus.o_State        = r_state;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pong_game_sequencer
// Directed bench for the match controller with SCORE_MAX=3, POINT_DELAY=4,
// AUTO_SERVE=10. Inputs change 1 ns after a rising edge; outputs are checked
// 1 ns after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_pong_game_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pong_game_sequencer_if #(.SW(2)) bus ();

    pong_game_sequencer #(
        .SCORE_MAX  (3),
        .POINT_DELAY(4),
        .AUTO_SERVE (10)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and confirm no two pulses are high together.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("pulse_exclusive", 32'($countones({bus.o_Ready, bus.o_Start, bus.o_Out}) <= 1), 32'd1);
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        chk(tag, 32'(bus.o_State), 32'(exp));
    endtask

    // Entered POINT this cycle: three more POINT cycles, then SERVE without o_Ready.
    task automatic point_wait();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("point_hold", 3'd3);
            chk("point_no_out", 32'(bus.o_Out), 32'd0);
        end
        tick();
        chk_state("point_to_serve", 3'd1);
        chk("point_no_ready", 32'(bus.o_Ready), 32'd0);
    endtask

    // From SERVE: press serve for one cycle and land in PLAY.
    task automatic serve_press();
        bus.i_Serve_Btn = 1'b1;
        tick();
        chk_state("serve_to_play", 3'd2);
        chk("serve_start", 32'(bus.o_Start), 32'd1);
        bus.i_Serve_Btn = 1'b0;
    endtask

    initial begin
        bus.i_Ready_Btn = 1'b0;
        bus.i_Serve_Btn = 1'b0;
        bus.i_Miss_P1   = 1'b0;
        bus.i_Miss_P2   = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk_state("rst_state", 3'd0);
        chk("rst_paddle_reset", 32'(bus.o_Paddle_Reset), 32'd1);
        chk("rst_ready", 32'(bus.o_Ready), 32'd0);
        chk("rst_score_p1", 32'(bus.o_Score_P1), 32'd0);
        chk("rst_score_p2", 32'(bus.o_Score_P2), 32'd0);
        chk("rst_game_over", 32'(bus.o_Game_Over), 32'd0);
        tick();
        tick();
        chk_state("home_idle", 3'd0);

        // 1: ready rise leaves HOME with a single o_Ready pulse
        bus.i_Ready_Btn = 1'b1;
        tick();
        chk_state("t1_serve", 3'd1);
        chk("t1_ready_pulse", 32'(bus.o_Ready), 32'd1);
        chk("t1_paddle_reset_low", 32'(bus.o_Paddle_Reset), 32'd0);
        tick();
        chk("t1_ready_one_cycle", 32'(bus.o_Ready), 32'd0);
        bus.i_Ready_Btn = 1'b0;

        // 2a: auto-serve exactly 10 cycles after SERVE entry (now at entry+1)
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_state("t2_wait_serve", 3'd1);
            chk("t2_no_start", 32'(bus.o_Start), 32'd0);
        end
        tick();
        chk_state("t2_auto_play", 3'd2);
        chk("t2_auto_start", 32'(bus.o_Start), 32'd1);
        tick();
        chk("t2_start_one_cycle", 32'(bus.o_Start), 32'd0);

        // 3: P2 misses -> P1 scores, o_Out, 4 POINT cycles, back to SERVE
        bus.i_Miss_P2 = 1'b1;
        tick();
        bus.i_Miss_P2 = 1'b0;
        chk_state("t3_point", 3'd3);
        chk("t3_score_p1", 32'(bus.o_Score_P1), 32'd1);
        chk("t3_out", 32'(bus.o_Out), 32'd1);
        point_wait();

        // 4: misses in SERVE ignored; 2b: serve button press; double miss
        bus.i_Miss_P1 = 1'b1;
        tick();
        bus.i_Miss_P1 = 1'b0;
        chk_state("t4_serve_ignores_miss", 3'd1);
        chk("t4_p2_unchanged", 32'(bus.o_Score_P2), 32'd0);
        bus.i_Serve_Btn = 1'b1;
        tick();
        chk_state("t2_press_play", 3'd2);
        chk("t2_press_start", 32'(bus.o_Start), 32'd1);
        tick();
        chk("t2_held_no_start", 32'(bus.o_Start), 32'd0);
        bus.i_Serve_Btn = 1'b0;
        bus.i_Miss_P1 = 1'b1;
        bus.i_Miss_P2 = 1'b1;
        tick();
        bus.i_Miss_P1 = 1'b0;
        bus.i_Miss_P2 = 1'b0;
        chk_state("t4_double_point", 3'd3);
        chk("t4_double_p1", 32'(bus.o_Score_P1), 32'd1);
        chk("t4_double_p2", 32'(bus.o_Score_P2), 32'd0);
        chk("t4_double_out", 32'(bus.o_Out), 32'd1);
        point_wait();

        // 5: P2 wins 3 points in a row
        for (int k = 1; k <= 3; k++) begin
            serve_press();
            bus.i_Miss_P1 = 1'b1;
            tick();
            bus.i_Miss_P1 = 1'b0;
            chk("t5_score_p2", 32'(bus.o_Score_P2), 32'(k));
            chk("t5_out", 32'(bus.o_Out), 32'd1);
            if (k < 3) begin
                chk_state("t5_point", 3'd3);
                point_wait();
            end else begin
                chk_state("t5_game_over_state", 3'd4);
                chk("t5_game_over", 32'(bus.o_Game_Over), 32'd1);
                chk("t5_winner", 32'(bus.o_Winner), 32'd1);
            end
        end
        bus.i_Miss_P2 = 1'b1;
        tick();
        bus.i_Miss_P2 = 1'b0;
        chk_state("t5_hold_state", 3'd4);
        chk("t5_hold_p2", 32'(bus.o_Score_P2), 32'd3);
        chk("t5_hold_p1", 32'(bus.o_Score_P1), 32'd1);
        chk("t5_hold_winner", 32'(bus.o_Winner), 32'd1);
        chk("t5_out_one_cycle", 32'(bus.o_Out), 32'd0);
        bus.i_Ready_Btn = 1'b1;
        tick();
        bus.i_Ready_Btn = 1'b0;
        chk_state("t5_home", 3'd0);
        chk("t5_clear_p1", 32'(bus.o_Score_P1), 32'd0);
        chk("t5_clear_p2", 32'(bus.o_Score_P2), 32'd0);
        chk("t5_game_over_low", 32'(bus.o_Game_Over), 32'd0);
        chk("t5_paddle_reset", 32'(bus.o_Paddle_Reset), 32'd1);

        // 6: reach PLAY with P1=2, then reset with serve held
        tick();
        bus.i_Ready_Btn = 1'b1;
        tick();
        bus.i_Ready_Btn = 1'b0;
        chk_state("t6_serve", 3'd1);
        for (int k = 1; k <= 2; k++) begin
            serve_press();
            bus.i_Miss_P2 = 1'b1;
            tick();
            bus.i_Miss_P2 = 1'b0;
            chk("t6_score_p1", 32'(bus.o_Score_P1), 32'(k));
            point_wait();
        end
        serve_press();
        bus.i_Serve_Btn = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("t6_rst_home", 3'd0);
        chk("t6_rst_p1", 32'(bus.o_Score_P1), 32'd0);
        chk("t6_rst_paddle_reset", 32'(bus.o_Paddle_Reset), 32'd1);
        chk("t6_rst_start", 32'(bus.o_Start), 32'd0);
        tick();
        bus.i_Ready_Btn = 1'b1;
        tick();
        bus.i_Ready_Btn = 1'b0;
        chk_state("t6_serve_again", 3'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("t6_held_no_edge", 3'd1);
            chk("t6_held_no_start", 32'(bus.o_Start), 32'd0);
        end
        bus.i_Serve_Btn = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
